gamepad_cursor_ctrl: RTL and testbench
======================================

# gamepad_cursor_ctrl

Converts live gaming-PMOD button levels for one controller into an on-screen cursor position with press-and-hold auto-repeat, edge clamping and a fast-move modifier. Sits between `game_controller_pmod` (upstream, button levels) and the top-level VGA RGB mux (downstream, consumes `cursor_on`). Position updates once per video frame, on `frame_tick`.

## Interface
- `H_RES`, 640: active width in pixels.
- `V_RES`, 480: active height in pixels.
- `CURSOR_SIZE`, 8: cursor square edge in pixels.
- `STEP`, 1: pixels per move, normal speed.
- `FAST_STEP`, 4: pixels per move while `btn_a` is held.
- `REPEAT_DELAY`, 15: frames a direction is held before auto-repeat starts.
- `REPEAT_RATE`, 3: frames between repeated moves.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_tick` in 1: single-cycle pulse, once per frame; the parent derives it from the vsync edge.
- `present` in 1: controller connected.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_a`, `btn_start` in 1 each: button levels, 1 = pressed.
- `pix_x`, `pix_y` in 10 each: current beam position.
- `cursor_x`, `cursor_y` out 10 each: registered top-left corner of the cursor.
- `cursor_on` out 1: beam is inside the cursor square.

## Operation
- Buttons are sampled only in a cycle where `frame_tick`=1. Between ticks, all state holds.
- When `present`=0, every button is treated as released.
- Opposing pairs cancel. up+down gives no vertical motion; left+right gives no horizontal motion.
- The masked result is `dir[3:0]` = {up, down, left, right}.
- Step size per move: `btn_a` ? `FAST_STEP` : `STEP`.
- The auto-repeat FSM runs on ticks only. It has states `IDLE`, `DELAY`, `REPEAT` and a frame counter `cnt`.
  - `IDLE`: if `dir`≠0, move now, go to `DELAY`, `cnt`=1.
  - `DELAY`: if `dir`=0, go to `IDLE`. If `dir` changed, move now and set `cnt`=1. If `cnt`=`REPEAT_DELAY`, move and go to `REPEAT` with `cnt`=1. Otherwise `cnt`++.
  - `REPEAT`: if `dir`=0, go to `IDLE`. If `dir` changed, move and go to `DELAY` with `cnt`=1. If `cnt`=`REPEAT_RATE`, move and set `cnt`=1. Otherwise `cnt`++.
- A move applies both axes of `dir` in the same tick, so diagonals are allowed.
- Clamping uses 11-bit signed intermediates and saturates:
  - x stays in [0, `H_RES`-`CURSOR_SIZE`] = [0, 632].
  - y stays in [0, `V_RES`-`CURSOR_SIZE`] = [0, 472].
  - There is no wrap-around.
- `btn_start` on a tick overrides everything else:
  - cursor goes to centre: x=(`H_RES`-`CURSOR_SIZE`)/2=316, y=(`V_RES`-`CURSOR_SIZE`)/2=236;
  - FSM goes to `IDLE`, `cnt`=0;
  - no move is applied that tick.
- `cursor_on` = (`cursor_x` ≤ `pix_x` < `cursor_x`+`CURSOR_SIZE`) AND (`cursor_y` ≤ `pix_y` < `cursor_y`+`CURSOR_SIZE`). It is combinational from the registered position and the `pix_*` inputs. Blanking is not this block's concern.
- Reset values: `cursor_x`=316, `cursor_y`=236, FSM `IDLE`, `cnt`=0. `cursor_on` then follows the pixel inputs.

## Timing
- A tick in cycle N updates `cursor_x`/`cursor_y` in cycle N+1 (one register stage).
- `cursor_on` has zero latency relative to `pix_*`. The parent's RGB register supplies the output stage.
- Moves after a new press, held continuously: ticks 0, 15, 18, 21, …
- Reset asserted mid-hold: the next cycle shows centre position and `IDLE`. A still-held direction then counts as a new press on the first tick after release of reset.
- Button changes between ticks are invisible to the block.

## Structure
- Shared include `gamepad_defs.vh` holds:
  - the FSM state encodings (`IDLE`=0, `DELAY`=1, `REPEAT`=2);
  - the default screen constants `H_RES`/`V_RES`, reused by `hvsync_generator` users.
- Natural sub-module: `autorepeat_timer`. It owns the FSM and `cnt`, takes `tick` and `dir`, and emits a one-cycle `move` strobe.
- Clamp arithmetic and the hit test stay in the top module.

## Test plan
- Reset, then 5 ticks with no buttons → `cursor_x`=316, `cursor_y`=236. With `pix_x`=316, `pix_y`=236, `cursor_on`=1; with `pix_x`=324, `cursor_on`=0.
- Hold right for 21 ticks → moves on ticks 0, 15, 18; `cursor_x`=319. Add `btn_a` on tick 21 → `cursor_x`=323.
- Hold left from x=2 with `btn_a`, 1 tick → `cursor_x`=0. Further repeats keep it at 0. Likewise hold down with `btn_a` from y=470 → `cursor_y`=472.
- Left+right+up held, 1 tick → x unchanged, y decreases by 1.
- Hold right for 10 ticks, then press `btn_start` → position becomes 316/236, FSM `IDLE`. The next tick with right still held moves immediately, as a new press.
- `present`=0 with right level asserted, 20 ticks → no motion. Assert `rst_n`=0 mid-REPEAT → centre position on the next cycle.

Source files
------------

// File: rtl/gamepad_cursor_ctrl_pkg.sv
// Shared types and default constants for the gamepad cursor block.
// Holds FSM state encodings, the direction bundle and the clamp helper.
package gamepad_cursor_ctrl_pkg;

    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_CURSOR_SIZE  = 8;
    localparam int DEF_STEP         = 1;
    localparam int DEF_FAST_STEP    = 4;
    localparam int DEF_REPEAT_DELAY = 15;
    localparam int DEF_REPEAT_RATE  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    // Saturate a signed candidate position into [0, hi].
    function automatic logic [9:0] clamp_pos(
        input logic signed [10:0] v,
        input logic [9:0]         hi
    );
        logic signed [10:0] hs;
        hs = $signed({1'b0, hi});
        if (v < 11'sd0)
            clamp_pos = '0;
        else if (v > hs)
            clamp_pos = hi;
        else
            clamp_pos = v[9:0];
    endfunction

endpackage

// File: rtl/gamepad_cursor_ctrl_if.sv
// Bus between the PMOD/VGA parent and the cursor block.
// master: parent (drives tick, buttons, beam); slave: cursor block.
interface gamepad_cursor_ctrl_if;

    logic       frame_tick;
    logic       present;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_a;
    logic       btn_start;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic       cursor_on;

    modport master (
        output frame_tick, present,
        output btn_up, btn_down, btn_left, btn_right,
        output btn_a, btn_start,
        output pix_x, pix_y,
        input  cursor_x, cursor_y, cursor_on
    );

    modport slave (
        input  frame_tick, present,
        input  btn_up, btn_down, btn_left, btn_right,
        input  btn_a, btn_start,
        input  pix_x, pix_y,
        output cursor_x, cursor_y, cursor_on
    );

endinterface

// File: rtl/gamepad_cursor_ctrl_autorepeat.sv
// Press-and-hold auto-repeat timer; advances only on tick.
// Ports: clk, rst_n (sync, low), tick, clear, dir in; move strobe out.
module autorepeat_timer
    import gamepad_cursor_ctrl_pkg::*;
#(
    parameter int DELAY_FRAMES = DEF_REPEAT_DELAY,
    parameter int RATE_FRAMES  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    input  dir_t dir,
    output logic move
);

    localparam int MAXF = (DELAY_FRAMES > RATE_FRAMES)
                        ? DELAY_FRAMES : RATE_FRAMES;
    localparam int CW   = $clog2(MAXF + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    rpt_state_t    state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    dir_t          dir_q, nxt_dir;

    // move is Mealy so the position register lands one cycle after tick.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_dir   = dir_q;
        move      = 1'b0;
        if (clear) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_dir   = '0;
        end else if (tick) begin
            nxt_dir = dir;
            unique case (state)
                IDLE: begin
                    if (dir != '0) begin
                        move      = 1'b1;
                        nxt_state = DELAY;
                        nxt_cnt   = ONE;
                    end
                end
                DELAY: begin
                    if (dir == '0) begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end else if (dir != dir_q) begin
                        move    = 1'b1;
                        nxt_cnt = ONE;
                    end else if (cnt == CW'(DELAY_FRAMES)) begin
                        move      = 1'b1;
                        nxt_state = REPEAT;
                        nxt_cnt   = ONE;
                    end else begin
                        nxt_cnt = cnt + ONE;
                    end
                end
                REPEAT: begin
                    if (dir == '0) begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end else if (dir != dir_q) begin
                        move      = 1'b1;
                        nxt_state = DELAY;
                        nxt_cnt   = ONE;
                    end else if (cnt == CW'(RATE_FRAMES)) begin
                        move    = 1'b1;
                        nxt_cnt = ONE;
                    end else begin
                        nxt_cnt = cnt + ONE;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dir_q <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            dir_q <= nxt_dir;
        end
    end

endmodule

// File: rtl/gamepad_cursor_ctrl.sv
// Gamepad buttons -> clamped cursor position plus beam hit test.
// Ports: clk, rst_n (sync, low), bus (slave: tick/buttons/beam in, cursor out).
module gamepad_cursor_ctrl
    import gamepad_cursor_ctrl_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int CURSOR_SIZE  = DEF_CURSOR_SIZE,
    parameter int STEP         = DEF_STEP,
    parameter int FAST_STEP    = DEF_FAST_STEP,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input logic            clk,
    input logic            rst_n,
    gamepad_cursor_ctrl_if.slave bus
);

    localparam logic [9:0] X_MAX = 10'(H_RES - CURSOR_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_RES - CURSOR_SIZE);
    localparam logic [9:0] X_MID = 10'((H_RES - CURSOR_SIZE) / 2);
    localparam logic [9:0] Y_MID = 10'((V_RES - CURSOR_SIZE) / 2);

    dir_t               dir;
    logic               fast;
    logic               start;
    logic               move;
    logic signed [10:0] step;
    logic signed [10:0] dx, dy;
    logic signed [10:0] nx, ny;
    logic [9:0]         cx_q, cy_q;
    logic [10:0]        x_end, y_end;

    // Absent controller reads as all released; opposing pairs cancel.
    always_comb begin
        dir.up    = bus.present & bus.btn_up   & ~bus.btn_down;
        dir.down  = bus.present & bus.btn_down & ~bus.btn_up;
        dir.left  = bus.present & bus.btn_left & ~bus.btn_right;
        dir.right = bus.present & bus.btn_right & ~bus.btn_left;
    end

    assign fast  = bus.present & bus.btn_a;
    assign start = bus.frame_tick & bus.present & bus.btn_start;

    always_comb begin
        step = fast ? 11'(FAST_STEP) : 11'(STEP);
        dx   = '0;
        dy   = '0;
        if (dir.right) dx = step;
        if (dir.left)  dx = -step;
        if (dir.down)  dy = step;
        if (dir.up)    dy = -step;
        nx = $signed({1'b0, cx_q}) + dx;
        ny = $signed({1'b0, cy_q}) + dy;
    end

    autorepeat_timer #(
        .DELAY_FRAMES (REPEAT_DELAY),
        .RATE_FRAMES  (REPEAT_RATE)
    ) u_rpt (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (bus.frame_tick),
        .clear (start),
        .dir   (dir),
        .move  (move)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cx_q <= X_MID;
            cy_q <= Y_MID;
        end else if (start) begin
            cx_q <= X_MID;
            cy_q <= Y_MID;
        end else if (move) begin
            cx_q <= clamp_pos(nx, X_MAX);
            cy_q <= clamp_pos(ny, Y_MAX);
        end
    end

    // 11-bit ends so a cursor at the right edge cannot overflow.
    assign x_end = {1'b0, cx_q} + 11'(CURSOR_SIZE);
    assign y_end = {1'b0, cy_q} + 11'(CURSOR_SIZE);

    assign bus.cursor_x  = cx_q;
    assign bus.cursor_y  = cy_q;
    assign bus.cursor_on = (bus.pix_x >= cx_q)
                        && ({1'b0, bus.pix_x} < x_end)
                        && (bus.pix_y >= cy_q)
                        && ({1'b0, bus.pix_y} < y_end);

endmodule

// File: tb/tb_gamepad_cursor_ctrl.sv
// Randomized bench for gamepad_cursor_ctrl against a hold-count model.
// Drives the bus interface, checks position and hit test per tick.
module tb_gamepad_cursor_ctrl;

    logic clk;
    logic rst_n;

    gamepad_cursor_ctrl_if bus();

    gamepad_cursor_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] U    = 4'b1000;
    localparam logic [3:0] D    = 4'b0100;
    localparam logic [3:0] L    = 4'b0010;
    localparam logic [3:0] R    = 4'b0001;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: position plus how long the current direction has been held.
    int mx, my, mk;
    logic [3:0] mprev;

    task automatic model_reset();
        mx = 316;
        my = 236;
        mk = 0;
        mprev = 4'b0000;
    endtask

    task automatic model_tick(input logic [3:0] d, input logic a,
                              input logic st, input logic pres);
        logic [3:0] b, md;
        bit mv;
        int s;
        b = pres ? d : 4'b0000;
        if (pres && st) begin
            mx = 316;
            my = 236;
            mprev = 4'b0000;
            return;
        end
        md = {b[3] & ~b[2], b[2] & ~b[3], b[1] & ~b[0], b[0] & ~b[1]};
        if (md == 4'b0000) begin
            mprev = 4'b0000;
            return;
        end
        if (md != mprev) begin
            mk = 0;
            mprev = md;
        end else begin
            mk++;
        end
        mv = (mk == 0) || (mk >= 15 && (mk - 15) % 3 == 0);
        if (!mv) return;
        s = (pres && a) ? 4 : 1;
        if (md[0]) mx = (mx + s > 632) ? 632 : mx + s;
        if (md[1]) mx = (mx - s < 0) ? 0 : mx - s;
        if (md[2]) my = (my + s > 472) ? 472 : my + s;
        if (md[3]) my = (my - s < 0) ? 0 : my - s;
    endtask

    task automatic drive_junk();
        bus.btn_up    = 1'($urandom);
        bus.btn_down  = 1'($urandom);
        bus.btn_left  = 1'($urandom);
        bus.btn_right = 1'($urandom);
        bus.btn_a     = 1'($urandom);
        bus.btn_start = 1'($urandom);
        bus.present   = 1'($urandom);
        bus.pix_x     = 10'($urandom_range(0, 639));
        bus.pix_y     = 10'($urandom_range(0, 479));
    endtask

    // Junk between ticks must be ignored; returns at a negedge after update.
    task automatic tick(input logic [3:0] d, input logic a,
                        input logic st, input logic pres);
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int i = 0; i < gap; i++) begin
            drive_junk();
            @(negedge clk);
        end
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = d;
        bus.btn_a      = a;
        bus.btn_start  = st;
        bus.present    = pres;
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        model_tick(d, a, st, pres);
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d, input logic a);
        tick(d, a, 1'b0, 1'b1);
        tick(NONE, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic move_to(input int tx, input int ty);
        while (mx - tx >= 4) press(L, 1'b1);
        while (mx > tx)      press(L, 1'b0);
        while (tx - mx >= 4) press(R, 1'b1);
        while (tx > mx)      press(R, 1'b0);
        while (my - ty >= 4) press(U, 1'b1);
        while (my > ty)      press(U, 1'b0);
        while (ty - my >= 4) press(D, 1'b1);
        while (ty > my)      press(D, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.cursor_x !== 10'd316 || bus.cursor_y !== 10'd236) begin
            n_bad++;
            $display("FAIL reset_pos: got %0d/%0d want 316/236",
                     bus.cursor_x, bus.cursor_y);
        end
        repeat (5) tick(NONE, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'd316 || bus.cursor_y !== 10'd236) begin
            n_bad++;
            $display("FAIL idle_ticks: got %0d/%0d want 316/236",
                     bus.cursor_x, bus.cursor_y);
        end
        bus.pix_x = 10'd316;
        bus.pix_y = 10'd236;
        #1;
        n_cmp++;
        if (bus.cursor_on !== 1'b1) begin
            n_bad++;
            $display("FAIL hit_corner: got %b want 1", bus.cursor_on);
        end
        bus.pix_x = 10'd323;
        bus.pix_y = 10'd243;
        #1;
        n_cmp++;
        if (bus.cursor_on !== 1'b1) begin
            n_bad++;
            $display("FAIL hit_far: got %b want 1", bus.cursor_on);
        end
        bus.pix_x = 10'd324;
        bus.pix_y = 10'd236;
        #1;
        n_cmp++;
        if (bus.cursor_on !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_right: got %b want 0", bus.cursor_on);
        end
        bus.pix_x = 10'd316;
        bus.pix_y = 10'd235;
        #1;
        n_cmp++;
        if (bus.cursor_on !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_above: got %b want 0", bus.cursor_on);
        end
    endtask

    task automatic test_hold_right();
        int moves;
        int last;
        moves = 0;
        for (int t = 0; t < 21; t++) begin
            last = int'(bus.cursor_x);
            tick(R, 1'b0, 1'b0, 1'b1);
            if (int'(bus.cursor_x) != last) moves++;
            n_cmp++;
            if (bus.cursor_x !== 10'(mx)) begin
                n_bad++;
                $display("FAIL hold_t%0d: got %0d want %0d",
                         t, bus.cursor_x, mx);
            end
        end
        n_cmp++;
        if (bus.cursor_x !== 10'd319 || moves != 3) begin
            n_bad++;
            $display("FAIL hold21: got x=%0d moves=%0d want 319/3",
                     bus.cursor_x, moves);
        end
        tick(R, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'd323) begin
            n_bad++;
            $display("FAIL fast_repeat: got %0d want 323", bus.cursor_x);
        end
        tick(NONE, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clamp();
        move_to(2, 470);
        n_cmp++;
        if (bus.cursor_x !== 10'd2 || bus.cursor_y !== 10'd470) begin
            n_bad++;
            $display("FAIL setup: got %0d/%0d want 2/470",
                     bus.cursor_x, bus.cursor_y);
        end
        tick(L, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'd0) begin
            n_bad++;
            $display("FAIL clamp_left: got %0d want 0", bus.cursor_x);
        end
        repeat (22) tick(L, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'd0) begin
            n_bad++;
            $display("FAIL clamp_left_rep: got %0d want 0", bus.cursor_x);
        end
        tick(D, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_y !== 10'd472) begin
            n_bad++;
            $display("FAIL clamp_down: got %0d want 472", bus.cursor_y);
        end
        repeat (22) tick(D, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_y !== 10'd472) begin
            n_bad++;
            $display("FAIL clamp_down_rep: got %0d want 472", bus.cursor_y);
        end
        tick(NONE, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_cancel();
        int x0, y0;
        x0 = mx;
        y0 = my;
        tick(L | R | U, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'(x0) || bus.cursor_y !== 10'(y0 - 1)) begin
            n_bad++;
            $display("FAIL cancel: got %0d/%0d want %0d/%0d",
                     bus.cursor_x, bus.cursor_y, x0, y0 - 1);
        end
        tick(U | D, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_y !== 10'(y0 - 1)) begin
            n_bad++;
            $display("FAIL cancel_ud: got %0d want %0d",
                     bus.cursor_y, y0 - 1);
        end
        tick(NONE, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_start();
        repeat (10) tick(R, 1'b0, 1'b0, 1'b1);
        tick(R, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'd316 || bus.cursor_y !== 10'd236) begin
            n_bad++;
            $display("FAIL start_centre: got %0d/%0d want 316/236",
                     bus.cursor_x, bus.cursor_y);
        end
        tick(R, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'd317) begin
            n_bad++;
            $display("FAIL start_repress: got %0d want 317", bus.cursor_x);
        end
        tick(NONE, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_present_and_reset();
        int x0;
        x0 = mx;
        repeat (20) tick(R, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.cursor_x !== 10'(x0)) begin
            n_bad++;
            $display("FAIL absent: got %0d want %0d", bus.cursor_x, x0);
        end
        repeat (20) tick(R, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.cursor_x !== 10'd316 || bus.cursor_y !== 10'd236) begin
            n_bad++;
            $display("FAIL reset_mid: got %0d/%0d want 316/236",
                     bus.cursor_x, bus.cursor_y);
        end
        rst_n = 1'b1;
        model_reset();
        tick(R, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.cursor_x !== 10'd317) begin
            n_bad++;
            $display("FAIL reset_repress: got %0d want 317", bus.cursor_x);
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic a, st, pres;
        int px, py;
        bit exp_on;
        d = NONE;
        a = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) d = 4'($urandom);
            if ($urandom_range(0, 7) == 0) a = 1'($urandom);
            st   = ($urandom_range(0, 63) == 0);
            pres = ($urandom_range(0, 15) != 0);
            tick(d, a, st, pres);
            n_cmp++;
            if (bus.cursor_x !== 10'(mx) || bus.cursor_y !== 10'(my)) begin
                n_bad++;
                $display("FAIL rand_t%0d: got %0d/%0d want %0d/%0d",
                         t, bus.cursor_x, bus.cursor_y, mx, my);
            end
            px = mx + int'($urandom_range(0, 11)) - 2;
            py = my + int'($urandom_range(0, 11)) - 2;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            bus.pix_x = 10'(px);
            bus.pix_y = 10'(py);
            #1;
            exp_on = (px >= mx) && (px < mx + 8) && (py >= my) && (py < my + 8);
            n_cmp++;
            if (bus.cursor_on !== exp_on) begin
                n_bad++;
                $display("FAIL rand_hit_t%0d: got %b want %b at %0d,%0d",
                         t, bus.cursor_on, exp_on, px, py);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.present    = 1'b1;
        bus.btn_up     = 1'b0;
        bus.btn_down   = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_a      = 1'b0;
        bus.btn_start  = 1'b0;
        bus.pix_x      = '0;
        bus.pix_y      = '0;
        model_reset();
        test_reset();
        test_hold_right();
        test_clamp();
        test_cancel();
        test_start();
        test_present_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
